// File: rtl/hamming_dec_engine.sv
// SECDED decoder engine: walks COUNT 16-bit Hamming codewords starting at SRC_BASE,
// corrects single-bit errors, flags double-bit errors, writes 11-bit messages to
// DST_BASE and raises halt when the block is done.
// Optional build macro: HAMMING_STATUS_EN puts a 2-bit status field in each output
// high byte; without it the high byte carries only d[11:9].
module hamming_dec_engine #(
    parameter int unsigned SRC_BASE = 64,
    parameter int unsigned DST_BASE = 94,
    parameter int unsigned COUNT    = 15
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    output logic       halt,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic [7:0] n_single,
    output logic [7:0] n_double
);

    localparam logic [7:0] SrcBase = 8'(SRC_BASE);
    localparam logic [7:0] DstBase = 8'(DST_BASE);
    localparam logic [6:0] LastIdx = 7'(COUNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] nsgl_q, nsgl_d;
    logic [7:0] ndbl_q, ndbl_d;

    logic [15:0] cw;
    logic [15:0] cw_fix;
    logic [3:0]  syn;
    logic        par;
    logic        is_single;
    logic        is_double;
    logic [10:0] data;
    logic [7:0]  out_hi;
    logic        wr_en;
    logic [7:0]  word_lo_addr;
    logic [7:0]  word_hi_addr;

    assign cw = {hi_q, lo_q};

    // Syndrome, overall parity, correction and data extraction of the latched codeword
    always_comb begin
        syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) begin
                syn = syn ^ 4'(k);
            end
        end
        par       = ^cw;
        is_single = par;
        is_double = !par && (syn != 4'd0);
        cw_fix    = cw;
        // S = 0 with odd parity means only p16 flipped; data bits stay as they are
        if (par && (syn != 4'd0)) begin
            cw_fix[syn] = ~cw[syn];
        end
        data = {cw_fix[15:9], cw_fix[7:5], cw_fix[3]};
`ifdef HAMMING_STATUS_EN
        out_hi = {is_double, is_single, 3'b000, data[10:8]};
`else
        out_hi = {5'b00000, data[10:8]};
`endif
    end

    // Byte addresses of the current word, 8-bit wrap-around
    always_comb begin
        word_lo_addr = {idx_q, 1'b0};
        word_hi_addr = {idx_q, 1'b1};
    end

    // Next-state, memory port and counter update logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        nsgl_d      = nsgl_q;
        ndbl_d      = ndbl_q;
        mem_addr    = 8'd0;
        wr_en       = 1'b0;
        mem_wr_data = 8'd0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRdLo;
                    idx_d   = 7'd0;
                    nsgl_d  = 8'd0;
                    ndbl_d  = 8'd0;
                end
            end
            StRdLo: begin
                mem_addr = SrcBase + word_lo_addr;
                lo_d     = mem_rd_data;
                state_d  = StRdHi;
            end
            StRdHi: begin
                mem_addr = SrcBase + word_hi_addr;
                hi_d     = mem_rd_data;
                state_d  = StWrLo;
            end
            StWrLo: begin
                mem_addr    = DstBase + word_lo_addr;
                wr_en       = 1'b1;
                mem_wr_data = data[7:0];
                if (is_single && (nsgl_q != 8'hFF)) begin
                    nsgl_d = nsgl_q + 8'd1;
                end
                if (is_double && (ndbl_q != 8'hFF)) begin
                    ndbl_d = ndbl_q + 8'd1;
                end
                state_d = StWrHi;
            end
            StWrHi: begin
                mem_addr    = DstBase + word_hi_addr;
                wr_en       = 1'b1;
                mem_wr_data = out_hi;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = StRdLo;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Suppress the strobe while reset is asserted so an aborted run writes nothing more
    assign mem_wr_en = wr_en && !reset;
    assign halt      = (state_q == StDone);
    assign n_single  = nsgl_q;
    assign n_double  = ndbl_q;

    // State register with synchronous reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 7'd0;
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
            nsgl_q  <= 8'd0;
            ndbl_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            nsgl_q  <= nsgl_d;
            ndbl_q  <= ndbl_d;
        end
    end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Self-checking bench for hamming_dec_engine: fixed vector table, random codewords
// against a behavioural SECDED model, mid-run reset and restart-from-DONE sequences.
module tb_hamming_dec_engine;

    localparam int SRC = 64;
    localparam int DST = 94;
    localparam int CNT = 15;
`ifdef HAMMING_STATUS_EN
    localparam bit Status = 1'b1;
`else
    localparam bit Status = 1'b0;
`endif

    logic       CLK;
    logic       reset;
    logic       start;
    logic       halt;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] n_single;
    logic [7:0] n_double;

    hamming_dec_engine #(
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .COUNT    (CNT)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .n_single    (n_single),
        .n_double    (n_double)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Source memory is written only by the stimulus, destination only by the DUT
    logic [7:0] src_mem [256];
    logic [7:0] dst_mem [256];
    int         wcnt [256];
    int         wr_total;
    int         snap [256];
    int         snap_total;

    assign mem_rd_data = src_mem[mem_addr];

    initial wr_total = 0;
    always @(posedge CLK) begin
        if (mem_wr_en) begin
            dst_mem[mem_addr] <= mem_wr_data;
            wcnt[mem_addr]    <= wcnt[mem_addr] + 1;
            wr_total          <= wr_total + 1;
        end
    end

    int checks;
    int failures;
    logic [15:0] cws [CNT];

    typedef struct {
        logic [15:0] cw;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [1:0]  flag;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Encode an 11-bit message: data at non-power-of-two positions, parity bits chosen
    // so the syndrome is zero, then overall parity in bit 0
    function automatic logic [15:0] encode(input int d);
        logic [15:0] c;
        int n;
        int s;
        c = 16'd0;
        n = 0;
        s = 0;
        for (int k = 3; k < 16; k++) begin
            if (k != 4 && k != 8) begin
                c[k] = d[n];
                n++;
            end
        end
        for (int k = 1; k < 16; k++) if (c[k]) s = s ^ k;
        for (int b = 0; b < 4; b++) if (s[b]) c[1 << b] = 1'b1;
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Reference decoder: cls 0 clean, 1 single corrected, 2 double detected
    task automatic ref_decode(input logic [15:0] cw, output logic [7:0] lo,
                              output logic [7:0] hi, output int cls);
        logic [15:0] c;
        int s;
        int p;
        int d;
        int n;
        logic [1:0] f;
        c = cw;
        s = 0;
        p = 0;
        for (int k = 1; k < 16; k++) if (cw[k]) s = s ^ k;
        for (int k = 0; k < 16; k++) p = p ^ int'(cw[k]);
        if (p == 1) begin
            cls = 1;
            if (s != 0) c[s] = ~c[s];
        end else if (s != 0) begin
            cls = 2;
        end else begin
            cls = 0;
        end
        d = 0;
        n = 0;
        for (int k = 3; k < 16; k++) begin
            if (k != 4 && k != 8) begin
                if (c[k]) d = d | (1 << n);
                n++;
            end
        end
        f  = 2'(cls);
        lo = 8'(d);
        hi = Status ? {f, 3'b000, 3'(d >> 8)} : {5'b00000, 3'(d >> 8)};
    endtask

    task automatic load_src();
        for (int i = 0; i < CNT; i++) begin
            src_mem[SRC + 2 * i]     = cws[i][7:0];
            src_mem[SRC + 2 * i + 1] = cws[i][15:8];
        end
    endtask

    task automatic take_snap();
        for (int a = 0; a < 256; a++) snap[a] = wcnt[a];
        snap_total = wr_total;
    endtask

    task automatic run_job(input string tag, input bit noisy);
        int cyc;
        take_snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " halt low after accept"}, halt, 1'b0);
        chk({tag, " n_single cleared"}, n_single, 8'd0);
        chk({tag, " n_double cleared"}, n_double, 8'd0);
        cyc = 0;
        while (halt !== 1'b1 && cyc < 500) begin
            if (noisy) start = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        start = 1'b0;
        chk({tag, " run latency"}, cyc, 32'd60);
    endtask

    task automatic verify_run(input string tag);
        int ns;
        int nd;
        int cls;
        logic [7:0] lo;
        logic [7:0] hi;
        ns = 0;
        nd = 0;
        for (int i = 0; i < CNT; i++) begin
            ref_decode(cws[i], lo, hi, cls);
            if (cls == 1) ns++;
            if (cls == 2) nd++;
            chk($sformatf("%s lo[%0d]", tag, i), dst_mem[DST + 2 * i], lo);
            chk($sformatf("%s hi[%0d]", tag, i), dst_mem[DST + 2 * i + 1], hi);
            chk($sformatf("%s wr once lo[%0d]", tag, i),
                wcnt[DST + 2 * i] - snap[DST + 2 * i], 1);
            chk($sformatf("%s wr once hi[%0d]", tag, i),
                wcnt[DST + 2 * i + 1] - snap[DST + 2 * i + 1], 1);
        end
        chk({tag, " total writes"}, wr_total - snap_total, 2 * CNT);
        chk({tag, " n_single"}, n_single, ns);
        chk({tag, " n_double"}, n_double, nd);
        repeat (3) tick();
        chk({tag, " halt held"}, halt, 1'b1);
        chk({tag, " n_single stable"}, n_single, ns);
        chk({tag, " mem_wr_en idle in DONE"}, mem_wr_en, 1'b0);
    endtask

    task automatic random_words();
        int d;
        int nf;
        int b1;
        int b2;
        for (int i = 0; i < CNT; i++) begin
            d  = $urandom_range(0, 2047);
            cws[i] = encode(d);
            nf = $urandom_range(0, 2);
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            if (nf >= 1) cws[i][b1] = ~cws[i][b1];
            if (nf == 2) cws[i][b2] = ~cws[i][b2];
        end
    endtask

    initial begin
        int ens;
        int end_;
        int hi_writes;
        logic [7:0] ehi;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        for (int a = 0; a < 256; a++) src_mem[a] = 8'($urandom);

        tbl[0] = '{16'h0000, 8'h00, 8'h00, 2'd0};
        tbl[1] = '{16'hDFFF, 8'hFF, 8'h07, 2'd1};
        tbl[2] = '{16'h0001, 8'h00, 8'h00, 2'd1};
        tbl[3] = '{16'h0006, 8'h00, 8'h00, 2'd2};
        tbl[4] = '{16'hFFFF, 8'hFF, 8'h07, 2'd0};
        tbl[5] = '{16'h000F, 8'h01, 8'h00, 2'd0};
        tbl[6] = '{16'h0007, 8'h01, 8'h00, 2'd1};
        tbl[7] = '{16'h8117, 8'h00, 8'h04, 2'd0};

        tick();
        tick();
        reset = 1'b0;
        chk("reset halt", halt, 1'b0);
        chk("reset mem_wr_en", mem_wr_en, 1'b0);
        chk("reset mem_addr", mem_addr, 8'd0);
        chk("reset mem_wr_data", mem_wr_data, 8'd0);
        chk("reset n_single", n_single, 8'd0);
        chk("reset n_double", n_double, 8'd0);

        // All-zero block
        for (int i = 0; i < CNT; i++) cws[i] = 16'h0000;
        load_src();
        run_job("zero", 1'b0);
        verify_run("zero");

        // Fixed vectors, remaining words clean zero
        for (int i = 0; i < CNT; i++) cws[i] = (i < 8) ? tbl[i].cw : 16'h0000;
        load_src();
        run_job("table", 1'b0);
        ens  = 0;
        end_ = 0;
        for (int i = 0; i < 8; i++) begin
            ehi = Status ? {tbl[i].flag, 3'b000, tbl[i].hi[2:0]} : tbl[i].hi;
            if (tbl[i].flag == 2'd1) ens++;
            if (tbl[i].flag == 2'd2) end_++;
            chk($sformatf("table lo[%0d] cw=%h", i, tbl[i].cw), dst_mem[DST + 2 * i], tbl[i].lo);
            chk($sformatf("table hi[%0d] cw=%h", i, tbl[i].cw), dst_mem[DST + 2 * i + 1], ehi);
        end
        chk("table n_single", n_single, ens);
        chk("table n_double", n_double, end_);

        // Restart straight from DONE rewrites identical results
        run_job("restart", 1'b0);
        verify_run("restart");

        // Reset during the third codeword's high-byte read
        random_words();
        load_src();
        take_snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("abort in RD_HI of word 2", mem_addr, 8'(SRC + 5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort halt", halt, 1'b0);
        chk("abort mem_wr_en", mem_wr_en, 1'b0);
        chk("abort mem_addr", mem_addr, 8'd0);
        chk("abort n_single", n_single, 8'd0);
        chk("abort n_double", n_double, 8'd0);
        repeat (5) tick();
        chk("abort halt stays low", halt, 1'b0);
        chk("abort writes", wr_total - snap_total, 4);
        hi_writes = 0;
        for (int a = DST + 4; a < 256; a++) hi_writes += wcnt[a] - snap[a];
        chk("abort no writes at 98+", hi_writes, 0);
        run_job("after abort", 1'b0);
        verify_run("after abort");

        // Random blocks; some with start toggling during the run
        for (int r = 0; r < 4; r++) begin
            random_words();
            load_src();
            run_job($sformatf("rand%0d", r), r[0]);
            verify_run($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_dec_engine.md
# hamming_dec_engine

Hardware SECDED decoder engine for the program-2 job. On a `start` pulse it walks a block of 16-bit Hamming codewords in data memory, corrects single-bit errors, and flags double-bit errors. It writes the recovered 11-bit messages back to memory, then raises `halt`. It attaches to the same byte-wide data-memory port and `start`/`halt` handshake as the core, and can replace the software decode routine.

## Interface
Parameters:
- `SRC_BASE`, 64: byte address of the first codeword's low byte.
- `DST_BASE`, 94: byte address of the first decoded word's low byte.
- `COUNT`, 15: number of codewords, 1..127.

Ports:
- `CLK` in, 1: the single clock; all state updates on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `start` in, 1: request; sampled only in IDLE and DONE.
- `halt` out, 1: ack/done, held high until the next accepted `start`.
- `mem_addr` out, 8: data-memory byte address.
- `mem_rd_data` in, 8: combinational read data for `mem_addr`, valid in the same cycle.
- `mem_wr_en` out, 1: write strobe, written at the rising edge.
- `mem_wr_data` out, 8: write data.
- `n_single` out, 8: count of corrected single-bit errors in the last run.
- `n_double` out, 8: count of detected double-bit errors in the last run.

## Operation
- Codeword layout, with cw[k] at Hamming position k (k = 1..15):
  - cw[15:9] = d[11:5], cw[8] = p8, cw[7:5] = d[4:2], cw[4] = p4, cw[3] = d[1], cw[2] = p2, cw[1] = p1.
  - cw[0] = p16 = overall even parity.
- Codeword i occupies low byte at SRC_BASE+2i and high byte at SRC_BASE+2i+1.
- Syndrome S[3:0] = XOR of all indices k (1..15) with cw[k] = 1.
- Overall parity P = ^cw[15:0].
- Classification:
  - S = 0 and P = 0: clean; data taken as is.
  - P = 1: single error. If S ≠ 0, invert cw[S] before data extraction; if S = 0, the error is in p16 and the data is untouched. Increment `n_single`.
  - S ≠ 0 and P = 0: double error. Data is extracted uncorrected; increment `n_double`.
- Output word i:
  - Low byte d[8:1] goes to DST_BASE+2i.
  - High byte goes to DST_BASE+2i+1; its layout is set under Configuration.
- FSM states:
  - IDLE → RD_LO on `start`.
  - RD_LO: addr = SRC+2i; latch low byte.
  - RD_HI: addr = SRC+2i+1; latch high byte.
  - WR_LO: decode combinationally; write the low byte; update the counters.
  - WR_HI: write the high byte. If i = COUNT−1, go to DONE; otherwise i++ and go to RD_LO.
  - DONE: `halt` = 1. On `start`, clear `halt`, i, and both counters, and go to RD_LO.
- `start` in RD_LO, RD_HI, WR_LO or WR_HI is ignored. A `start` held high in DONE restarts exactly once per accepted sample.
- Counters saturate at 255. Address arithmetic is 8-bit modulo 256.

## Timing
- Reset values: `halt` = 0, `mem_wr_en` = 0, `mem_addr` = 0, `mem_wr_data` = 0, `n_single` = 0, `n_double` = 0; state = IDLE, i = 0.
- Reset asserted mid-run: enter IDLE on the next edge with no further writes. Bytes already written stay in memory.
- `start` sampled high at edge t: RD_LO occupies cycle t+1, and `halt` is low from t+1 if it was set.
- Each codeword takes 4 cycles. `halt` rises at the edge ending the last WR_HI: 4·COUNT cycles after acceptance, 60 for the default COUNT.
- `mem_wr_en` is high only in WR_LO and WR_HI; exactly 2·COUNT writes per run.
- `n_single` and `n_double` are stable and final whenever `halt` = 1.

## Configuration
- `HAMMING_STATUS_EN` defined:
  - High byte = {F[1:0], 3'b000, d[11:9]}.
  - F = 2'b00 clean, 2'b01 single corrected (including a p16-only error), 2'b10 double detected.
- Not defined:
  - High byte = {5'b00000, d[11:9]}.
  - `n_single` and `n_double` still operate.

## Test plan
- Reset for 2 cycles, then pulse `start` with 15 codewords of 0x0000 → 60 cycles later `halt` = 1; bytes 94..123 all 0x00; `n_single` = `n_double` = 0.
- Codeword 0xFFFF (d = 0x7FF) with one bit flipped (bit 13 → 0xDFFF) → low byte 0xFF; high byte 0x07 without the macro, 0x47 with it; `n_single` = 1.
- Codeword 0x0001 (p16-only error) → data 0x000; `n_single` increments; no data bit changes.
- Codeword 0x0006 (bits 1 and 2 flipped, S = 3, P = 0) → data written uncorrected as 0x00/0x00 (high byte 0x80 with the macro); `n_double` = 1.
- Assert `reset` during the 3rd codeword's RD_HI → no writes to 98 and above; `halt` = 0. A subsequent `start` completes a full, correct run.
- Second `start` while `halt` = 1 → `halt` drops the next cycle; counters reset to 0; results are rewritten identically; `start` pulses during a run are ignored.
